// File: rtl/lcm_from_gcd.sv
// lcm_from_gcd: LCM as floor(a/gcd)*b via serial restoring divide then shift-add multiply.
// Fixed latency of 2*WIDTH cycles for non-zero operands; zero operands short-circuit to a zero result.
module lcm_from_gcd #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_gcd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lcm,
    output logic             out_ovf,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_quo, r_rem, r_div, r_b, r_lcm;
    logic               r_ovf;
    logic [2*WIDTH-1:0] r_acc, w_acc;
    logic [WIDTH:0]     w_shift, w_diff;
    logic               w_fit, w_last, w_zero;

    assign w_zero  = (in_a == '0) || (in_b == '0) || (in_gcd == '0);
    assign w_last  = r_cnt == CW'(WIDTH - 1);
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_fit   = w_shift >= {1'b0, r_div};
    // r_quo doubles as the multiplier during MUL, consumed MSB first
    assign w_acc   = {r_acc[2*WIDTH-2:0], 1'b0} + (r_quo[WIDTH-1] ? {{WIDTH{1'b0}}, r_b} : '0);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? (w_zero ? DONE : DIV) : IDLE;
            DIV:     w_next = w_last ? MUL : DIV;
            MUL:     w_next = w_last ? DONE : MUL;
            default: w_next = out_ready ? IDLE : DONE;
        endcase
    end

    always_comb begin
        in_ready  = r_state == IDLE;
        out_valid = r_state == DONE;
        busy      = r_state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lcm <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_quo <= in_a;
                    r_rem <= '0;
                    r_div <= in_gcd;
                    r_b   <= in_b;
                    r_acc <= '0;
                    r_cnt <= '0;
                    if (w_zero) begin
                        r_lcm <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                DIV: begin
                    r_rem <= w_fit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_fit};
                    r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                end
                MUL: begin
                    r_acc <= w_acc;
                    r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                    if (w_last) begin
                        r_lcm <= w_acc[WIDTH-1:0];
                        r_ovf <= |w_acc[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_lcm = r_lcm;
    assign out_ovf = r_ovf;
endmodule

// File: tb/tb_lcm_from_gcd.sv
// tb_lcm_from_gcd: directed and randomized checks of lcm_from_gcd against an arithmetic model.
module tb_lcm_from_gcd;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0, in_b = '0, in_gcd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_lcm;
    logic        out_ovf;
    logic        busy;
    int          n_checks = 0;
    int          n_fails = 0;

    lcm_from_gcd #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_gcd(in_gcd), .out_valid(out_valid),
        .out_ready(out_ready), .out_lcm(out_lcm), .out_ovf(out_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] g);
        if (a == 0 || b == 0 || g == 0) return 64'd0;
        return {32'd0, a / g} * {32'd0, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] g, output int lat);
        int w = 0;
        while (!in_ready && w < 200) begin
            step();
            w++;
        end
        in_a = a; in_b = b; in_gcd = g; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_ctrl: in_ready=%b busy=%b out_valid=%b, required 1 0 0", in_ready, busy, out_valid);
        end
        n_checks++;
        if (out_lcm !== 32'd0 || out_ovf !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_data: lcm=%h ovf=%b, required 0 0", out_lcm, out_ovf);
        end
    endtask

    task automatic test_vector(input string name, input logic [31:0] a, input logic [31:0] b, input logic [31:0] g);
        logic [63:0] e;
        int lat, e_lat;
        e = model(a, b, g);
        e_lat = (a == 0 || b == 0 || g == 0) ? 0 : 64;
        out_ready = 1'b1;
        send(a, b, g, lat);
        n_checks++;
        if (lat !== e_lat) begin
            n_fails++;
            $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, e_lat);
        end
        n_checks++;
        if (out_lcm !== e[31:0]) begin
            n_fails++;
            $display("FAIL %s lcm: got %h, required %h", name, out_lcm, e[31:0]);
        end
        n_checks++;
        if (out_ovf !== (|e[63:32])) begin
            n_fails++;
            $display("FAIL %s ovf: got %b, required %b", name, out_ovf, |e[63:32]);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fails++;
            $display("FAIL %s busy_done: got %b, required 1", name, busy);
        end
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL %s release: in_ready=%b out_valid=%b, required 1 0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        send(32'd144, 32'd120, 32'd24, lat);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_lcm !== 32'd720 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
                n_fails++;
                $display("FAIL bp_hold[%0d]: valid=%b lcm=%0d ovf=%b in_ready=%b, required 1 720 0 0",
                         i, out_valid, out_lcm, out_ovf, in_ready);
            end
            if (i == 3) begin
                in_a = 32'd5; in_b = 32'd5; in_gcd = 32'd5; in_valid = 1'b1;
            end
            step();
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        repeat (3) step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++;
            $display("FAIL bp_ignored_pulse: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_div();
        bit seen = 1'b0;
        out_ready = 1'b1;
        in_a = 32'd9; in_b = 32'd15; in_gcd = 32'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_lcm !== 32'd0) begin
            n_fails++;
            $display("FAIL mid_reset_state: in_ready=%b busy=%b valid=%b lcm=%h, required 1 0 0 0",
                     in_ready, busy, out_valid, out_lcm);
        end
        repeat (80) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_reset_no_result: out_valid seen=%b, required 0", seen);
        end
        test_vector("after_reset", 32'd21, 32'd6, 32'd3);
    endtask

    task automatic test_random();
        logic [31:0] a, b, g;
        for (int i = 0; i < 12; i++) begin
            g = $urandom_range(1, 4095);
            a = (i % 3 == 0) ? $urandom : g * $urandom_range(1, 100000);
            b = (i % 2 == 0) ? $urandom : $urandom_range(0, 5000);
            test_vector($sformatf("rand%0d", i), a, b, g);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta[6], tb_[6], tg[6];
        logic [63:0] q[$];
        logic [63:0] e;
        int acc = 0, got = 0, cyc = 0;
        bit ir, seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tg[i] = $urandom_range(1, 300);
            ta[i] = tg[i] * $urandom_range(1, 20000);
            tb_[i] = $urandom_range(1, 1 << 20);
        end
        ta[2] = 32'd0;
        out_ready = 1'b1;
        in_a = ta[0]; in_b = tb_[0]; in_gcd = tg[0]; in_valid = 1'b1;
        while (got < 6 && cyc < 2000) begin
            if (out_valid) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fails++;
                    $display("FAIL b2b_extra: unexpected result %h", out_lcm);
                end else begin
                    e = q.pop_front();
                    if (out_lcm !== e[31:0] || out_ovf !== (|e[63:32])) begin
                        n_fails++;
                        $display("FAIL b2b_result[%0d]: got %h/%b, required %h/%b", got, out_lcm, out_ovf, e[31:0], |e[63:32]);
                    end
                end
                got++;
            end
            ir = in_ready;
            step();
            cyc++;
            if (ir && in_valid) begin
                q.push_back(model(in_a, in_b, in_gcd));
                acc++;
                if (acc < 6) begin
                    in_a = ta[acc]; in_b = tb_[acc]; in_gcd = tg[acc];
                end else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (got !== 6 || q.size() !== 0) begin
            n_fails++;
            $display("FAIL b2b_count: received %0d pending %0d, required 6 0", got, q.size());
        end
        repeat (70) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fails++;
            $display("FAIL b2b_duplicate: extra out_valid seen=%b, required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_vector("basic_9_15_3", 32'd9, 32'd15, 32'd3);
        test_vector("144_120_24", 32'd144, 32'd120, 32'd24);
        test_vector("zero_a", 32'd0, 32'd7, 32'd7);
        test_vector("overflow", 32'h0001_0000, 32'h0001_0000, 32'd1);
        test_vector("max_a", 32'hFFFF_FFFF, 32'd1, 32'd1);
        test_vector("non_divisor", 32'd10, 32'd7, 32'd3);
        test_vector("zero_gcd", 32'd12, 32'd5, 32'd0);
        test_backpressure();
        test_reset_mid_div();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
